// File: rtl/ms_mul_pkg.sv
// rtl/ms_mul_pkg.sv - shared state encoding and default widths for the multiplier scheduler
package ms_mul_pkg;

    localparam int DEF_DATA_WIDTH = 5;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_TIMEOUT    = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/ms_mul_sched_rr_arbiter.sv
// rtl/ms_mul_sched_rr_arbiter.sv - round-robin pick starting at ptr, wrapping upward
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    int j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && req_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ms_mul_sched.sv
// rtl/ms_mul_sched.sv - shares one serial multiplier among NUM_REQ requesters, one op at a time
module ms_mul_sched
    import ms_mul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_b,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
    output logic [2*DATA_WIDTH-1:0]          rsp_data,
    output logic                             rsp_err,
    output logic                             mul_rst,
    output logic                             mul_en,
    output logic [DATA_WIDTH-1:0]            mul_a,
    output logic [DATA_WIDTH-1:0]            mul_b,
    input  logic [2*DATA_WIDTH-1:0]          mul_result,
    input  logic                             mul_done
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);

    state_t                  state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [IW-1:0]           id_q, id_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [2*DATA_WIDTH-1:0] data_q, data_d;
    logic                    err_q, err_d;
    logic                    valid_q, valid_d;
    logic                    en_q, en_d;
    logic                    mrst_q, mrst_d;

    logic [NUM_REQ-1:0]      gnt_oh;
    logic [IW-1:0]           gnt_idx;
    logic                    gnt_any;
    logic [DATA_WIDTH-1:0]   sel_a;
    logic [DATA_WIDTH-1:0]   sel_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (gnt_oh),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IW'(i)) begin
                sel_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        err_d     = err_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                // Masking with rst keeps a requester from seeing an accept that reset discards.
                if (gnt_any && !rst) begin
                    req_ready = gnt_oh;
                    id_d      = gnt_idx;
                    a_d       = sel_a;
                    b_d       = sel_b;
                    state_d   = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (mul_done) begin
                    data_d  = mul_result;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    ptr_d   = (id_q == IW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == RESP);
        en_d    = (state_d == RUN);
        mrst_d  = (state_d == CLR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            en_q    <= 1'b0;
            mrst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            en_q    <= en_d;
            mrst_q  <= mrst_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign mul_rst   = mrst_q;
    assign mul_en    = en_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;

endmodule

// File: tb/tb_ms_mul_sched.sv
// tb/tb_ms_mul_sched.sv - directed bench for ms_mul_sched with a behavioural serial multiplier
module tb_ms_mul_sched;

    localparam int DW = 5;
    localparam int N  = 4;
    localparam int TO = 64;
    localparam int IW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_a = '0;
    logic [N*DW-1:0]   req_b = '0;
    logic [N-1:0]      req_ready;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [IW-1:0]     rsp_id;
    logic [2*DW-1:0]   rsp_data;
    logic              rsp_err;
    logic              mul_rst;
    logic              mul_en;
    logic [DW-1:0]     mul_a;
    logic [DW-1:0]     mul_b;
    logic [2*DW-1:0]   mul_result;
    logic              mul_done = 1'b0;

    int errors = 0;
    int checks = 0;
    int lat    = 3;
    bit stub   = 1'b0;
    int mcnt   = 0;

    ms_mul_sched #(.DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .mul_rst    (mul_rst),
        .mul_en     (mul_en),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .mul_done   (mul_done)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: done rises after lat enabled cycles; stub mode never finishes.
    assign mul_result = {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, mul_b};
    always @(posedge clk) begin
        if (mul_rst) begin
            mcnt     <= 0;
            mul_done <= 1'b0;
        end else if (mul_en && !stub) begin
            mcnt <= mcnt + 1;
            if (mcnt == lat - 1) mul_done <= 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic observe_op(input int max_cyc, input bit drop, output bit got,
                              output logic [N-1:0] grant, output int grant_cnt,
                              output int rst_cnt, output int run_cnt,
                              output logic [DW-1:0] ra, output logic [DW-1:0] rb,
                              output logic [IW-1:0] id, output logic [2*DW-1:0] data,
                              output logic err);
        bit drop_pending;
        bit run_seen;
        got = 0; grant = '0; grant_cnt = 0; rst_cnt = 0; run_cnt = 0;
        ra = '0; rb = '0; id = '0; data = '0; err = 1'b0;
        drop_pending = 0; run_seen = 0;
        for (int c = 0; c < max_cyc && !got; c++) begin
            #1;
            if (req_ready != '0) begin
                grant = req_ready;
                grant_cnt++;
                drop_pending = drop;
            end
            if (mul_rst) rst_cnt++;
            if (mul_en) begin
                if (!run_seen) begin
                    ra = mul_a;
                    rb = mul_b;
                    run_seen = 1;
                end
                run_cnt++;
            end
            if (rsp_valid) begin
                got  = 1;
                id   = rsp_id;
                data = rsp_data;
                err  = rsp_err;
            end
            @(negedge clk);
            if (drop_pending) begin
                req_valid = req_valid & ~grant;
                drop_pending = 0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (req_ready !== '0)   begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_data !== '0)    begin errors++; $display("FAIL reset_rsp_data: got %0d expected 0", rsp_data); end
        checks++; if (rsp_id !== '0)      begin errors++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (rsp_err !== 1'b0)   begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        checks++; if (mul_en !== 1'b0)    begin errors++; $display("FAIL reset_mul_en: got %b expected 0", mul_en); end
        checks++; if (mul_rst !== 1'b1)   begin errors++; $display("FAIL reset_mul_rst: got %b expected 1", mul_rst); end
        checks++; if (mul_a !== '0 || mul_b !== '0) begin errors++; $display("FAIL reset_mul_ab: got %0d,%0d expected 0,0", mul_a, mul_b); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (mul_rst !== 1'b0)   begin errors++; $display("FAIL idle_mul_rst: got %b expected 0", mul_rst); end
        @(negedge clk);
    endtask

    task automatic test_single;
        bit got; logic [N-1:0] g; int gc, rc, rn;
        logic [DW-1:0] ra, rb; logic [IW-1:0] id; logic [2*DW-1:0] d; logic e;
        stub = 0; lat = 3; rsp_ready = 1'b1;
        req_a = '0; req_b = '0;
        req_a[2*DW +: DW] = 5'd3;
        req_b[2*DW +: DW] = 5'd7;
        req_valid = 4'b0100;
        observe_op(40, 1, got, g, gc, rc, rn, ra, rb, id, d, e);
        checks++; if (got !== 1'b1)    begin errors++; $display("FAIL single_rsp_seen: got %b expected 1", got); end
        checks++; if (g !== 4'b0100)   begin errors++; $display("FAIL single_grant: got %b expected 0100", g); end
        checks++; if (gc !== 1)        begin errors++; $display("FAIL single_grant_cycles: got %0d expected 1", gc); end
        checks++; if (rc !== 1)        begin errors++; $display("FAIL single_clr_pulses: got %0d expected 1", rc); end
        checks++; if (ra !== 5'd3 || rb !== 5'd7) begin errors++; $display("FAIL single_mul_ops: got %0d,%0d expected 3,7", ra, rb); end
        checks++; if (id !== 2'd2)     begin errors++; $display("FAIL single_rsp_id: got %0d expected 2", id); end
        checks++; if (d !== 10'd21)    begin errors++; $display("FAIL single_rsp_data: got %0d expected 21", d); end
        checks++; if (e !== 1'b0)      begin errors++; $display("FAIL single_rsp_err: got %b expected 0", e); end
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b expected 0", rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        bit got; logic [N-1:0] g; int gc, rc, rn;
        logic [DW-1:0] ra, rb; logic [IW-1:0] id; logic [2*DW-1:0] d; logic e;
        logic [N-1:0]    exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [2*DW-1:0] exp_d [5] = '{10'd6, 10'd20, 10'd42, 10'd90, 10'd6};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req_a = {5'd9, 5'd6, 5'd4, 5'd2};
        req_b = {5'd10, 5'd7, 5'd5, 5'd3};
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            observe_op(40, 0, got, g, gc, rc, rn, ra, rb, id, d, e);
            checks++; if (g !== exp_g[k]) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, g, exp_g[k]); end
            checks++; if (id !== IW'($clog2(int'(exp_g[k])))) begin errors++; $display("FAIL rr_id[%0d]: got %0d expected %0d", k, id, $clog2(int'(exp_g[k]))); end
            checks++; if (d !== exp_d[k]) begin errors++; $display("FAIL rr_data[%0d]: got %0d expected %0d", k, d, exp_d[k]); end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        bit got; logic [N-1:0] g; int gc, rc, rn;
        logic [DW-1:0] ra, rb; logic [IW-1:0] id; logic [2*DW-1:0] d; logic e;
        stub = 1;
        req_a[1*DW +: DW] = 5'd5;
        req_b[1*DW +: DW] = 5'd6;
        req_valid = 4'b0010;
        observe_op(120, 1, got, g, gc, rc, rn, ra, rb, id, d, e);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL timeout_rsp_seen: got %b expected 1", got); end
        checks++; if (rn !== TO)    begin errors++; $display("FAIL timeout_run_cycles: got %0d expected %0d", rn, TO); end
        checks++; if (e !== 1'b1)   begin errors++; $display("FAIL timeout_err: got %b expected 1", e); end
        checks++; if (d !== '0)     begin errors++; $display("FAIL timeout_data: got %0d expected 0", d); end
        checks++; if (id !== 2'd1)  begin errors++; $display("FAIL timeout_id: got %0d expected 1", id); end
        stub = 0;
        @(negedge clk);
    endtask

    task automatic test_stall;
        bit got; logic [N-1:0] g; int gc, rc, rn;
        logic [DW-1:0] ra, rb; logic [IW-1:0] id; logic [2*DW-1:0] d; logic e;
        rsp_ready = 1'b0;
        req_a[3*DW +: DW] = 5'd31; req_b[3*DW +: DW] = 5'd31;
        req_a[0*DW +: DW] = 5'd2;  req_b[0*DW +: DW] = 5'd3;
        req_valid = 4'b1001;
        observe_op(40, 1, got, g, gc, rc, rn, ra, rb, id, d, e);
        checks++; if (g !== 4'b1000) begin errors++; $display("FAIL stall_grant: got %b expected 1000", g); end
        checks++; if (d !== 10'd961) begin errors++; $display("FAIL stall_data: got %0d expected 961", d); end
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 10'd961 || rsp_id !== 2'd3 || req_ready !== '0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b data=%0d id=%0d ready=%b expected 1/961/3/0000",
                         k, rsp_valid, rsp_data, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        observe_op(40, 1, got, g, gc, rc, rn, ra, rb, id, d, e);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL stall_next_grant: got %b expected 0001", g); end
        checks++; if (d !== 10'd6)   begin errors++; $display("FAIL stall_next_data: got %0d expected 6", d); end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        bit got; logic [N-1:0] g; int gc, rc, rn;
        logic [DW-1:0] ra, rb; logic [IW-1:0] id; logic [2*DW-1:0] d; logic e;
        int run_idx; bit hit; bit granted; int spurious;
        lat = 8; run_idx = 0; hit = 0; granted = 0; spurious = 0;
        req_a[1*DW +: DW] = 5'd4; req_b[1*DW +: DW] = 5'd5;
        req_valid = 4'b0010;
        for (int c = 0; c < 30 && !hit; c++) begin
            #1;
            if (req_ready != '0) granted = 1;
            if (mul_en) begin
                if (run_idx == 3) begin
                    rst = 1'b1;
                    hit = 1;
                end
                run_idx++;
            end
            @(negedge clk);
            if (granted) req_valid = '0;
        end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL midrst_reach_run3: got %b expected 1", hit); end
        #1;
        checks++;
        if (mul_rst !== 1'b1 || mul_en !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== '0 ||
            rsp_id !== '0 || rsp_err !== 1'b0 || mul_a !== '0 || mul_b !== '0 || req_ready !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got rst=%b en=%b v=%b d=%0d id=%0d err=%b a=%0d b=%0d rdy=%b expected 1 0 0 0 0 0 0 0 0000",
                     mul_rst, mul_en, rsp_valid, rsp_data, rsp_id, rsp_err, mul_a, mul_b, req_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rsp_valid) spurious++;
            @(negedge clk);
        end
        checks++; if (spurious !== 0) begin errors++; $display("FAIL midrst_no_response: got %0d expected 0", spurious); end
        lat = 3;
        req_valid = 4'b0010;
        observe_op(40, 1, got, g, gc, rc, rn, ra, rb, id, d, e);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL midrst_fresh_grant: got %b expected 0010", g); end
        checks++; if (id !== 2'd1)   begin errors++; $display("FAIL midrst_fresh_id: got %0d expected 1", id); end
        checks++; if (d !== 10'd20 || e !== 1'b0) begin errors++; $display("FAIL midrst_fresh_data: got %0d err=%b expected 20 err=0", d, e); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_stall();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ms_mul_sched.md
MS_MUL_SCHED -- requirements
Module: ms_mul_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5, operand width of the shared ms_serial_by2_mul.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum RUN cycles before abort (>=2).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  NUM_REQ  per-requester operation request.
REQ-007 SHALL have port req_a  in  NUM_REQ*DATA_WIDTH  operand A; slice i belongs to requester i.
REQ-008 SHALL have port req_b  in  NUM_REQ*DATA_WIDTH  operand B; slice i belongs to requester i.
REQ-009 SHALL have port req_ready  out  NUM_REQ  one-hot accept strobe.
REQ-010 SHALL have port rsp_valid  out  1  result available.
REQ-011 SHALL have port rsp_ready  in  1  consumer accepts result.
REQ-012 SHALL have port rsp_id  out  $clog2(NUM_REQ)  requester index of the result.
REQ-013 SHALL have port rsp_data  out  2*DATA_WIDTH  product.
REQ-014 SHALL have port rsp_err  out  1  operation timed out.
REQ-015 SHALL have port mul_rst  out  1  reset to multiplier.
REQ-016 SHALL have port mul_en  out  1  enable to multiplier.
REQ-017 SHALL have port mul_a  out  DATA_WIDTH  multiplier input 0.
REQ-018 SHALL have port mul_b  out  DATA_WIDTH  multiplier input 1.
REQ-019 SHALL have port mul_result  in  2*DATA_WIDTH  multiplier bin_data_out.
REQ-020 SHALL have port mul_done  in  1  multiplier done.

Function
REQ-021 SHALL implement FSM IDLE -> CLR -> RUN -> RESP -> IDLE.
REQ-022 IDLE: if any req_valid, SHALL assert req_ready[g] for exactly one cycle for round-robin winner g, latch operands and g, go CLR; otherwise stay in IDLE.
REQ-023 Round-robin SHALL search from index ptr upward with wrap; ptr resets to 0 and becomes g+1 mod NUM_REQ on leaving RESP.
REQ-024 req_ready SHALL be zero in every state except IDLE; requesters hold valid and operands until ready.
REQ-025 CLR: mul_rst=1, mul_en=0 for exactly one cycle, then go RUN.
REQ-026 RUN: mul_en=1, mul_rst=0, mul_a/mul_b held at latched operands every cycle; cycle counter counts from 0.
REQ-027 RUN: the first cycle mul_done=1 SHALL capture mul_result into rsp_data, clear rsp_err, go RESP.
REQ-028 RUN: if counter reaches TIMEOUT-1 without mul_done, SHALL set rsp_data=0, rsp_err=1, go RESP; mul_done in that same cycle wins over timeout.
REQ-029 RESP: rsp_valid=1, mul_en=0; rsp_data/rsp_id/rsp_err stable until rsp_valid&&rsp_ready, then go IDLE.
REQ-030 mul_done outside RUN SHALL be ignored.
REQ-031 Minimum occupancy SHALL be 1 (IDLE) + 1 (CLR) + multiplier latency + 1 (RESP) cycles; no overlap of operations.

Reset
REQ-032 On rst=1 at a clock edge, state SHALL become IDLE and ptr, counter, req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, mul_en, mul_a and mul_b SHALL become 0, and mul_rst SHALL become 1.
REQ-033 Reset mid-operation SHALL discard the in-flight operation with no response issued.

Structure
REQ-034 Package ms_mul_pkg SHALL hold the state enum (IDLE, CLR, RUN, RESP) and the default width constants.
REQ-035 Round-robin selection SHALL be the sub-module rr_arbiter (request vector, ptr -> one-hot grant, index, any).

Verification
REQ-036 Requester 2 only, a=3, b=7, ms_serial_by2_mul attached -> req_ready[2] one cycle, one CLR pulse, rsp_id=2, rsp_data=21, rsp_err=0.
REQ-037 All four requesters valid continuously, each with distinct operands -> grants in order 0,1,2,3,0; each rsp_data matches its own product.
REQ-038 Stub multiplier that never asserts done -> rsp_valid after TIMEOUT RUN cycles with rsp_err=1, rsp_data=0.
REQ-039 a=31, b=31, rsp_ready held 0 for 10 cycles -> rsp_data=961 stable; no req_ready asserted until the handshake completes.
REQ-040 rst asserted in RUN cycle 3 -> next cycle IDLE, all outputs at reset values; a fresh request completes correctly.
